// File: rtl/light_pkg.sv
// Shared encodings, table lengths and frame lookup for the lamp pattern controller.
package light_pkg;

    typedef enum logic [1:0] {
        MODE_FLASH = 2'd0,
        MODE_CHASE = 2'd1,
        MODE_ALT   = 2'd2,
        MODE_AUTO  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    localparam logic [3:0] LEN_FLASH = 4'd2;
    localparam logic [3:0] LEN_CHASE = 4'd8;
    localparam logic [3:0] LEN_ALT   = 4'd2;
    localparam logic [3:0] LEN_AUTO  = 4'd12;

    localparam logic [7:0] FRAME_OFF   = 8'h00;
    localparam logic [7:0] FRAME_ON    = 8'hFF;
    localparam logic [7:0] FRAME_ALT_A = 8'h55;
    localparam logic [7:0] FRAME_ALT_B = 8'hAA;
    localparam logic [7:0] FRAME_LAMP0 = 8'h01;

    function automatic logic [3:0] table_len(input mode_e m);
        logic [3:0] len;
        unique case (m)
            MODE_FLASH: len = LEN_FLASH;
            MODE_CHASE: len = LEN_CHASE;
            MODE_ALT:   len = LEN_ALT;
            MODE_AUTO:  len = LEN_AUTO;
            default:    len = LEN_FLASH;
        endcase
        return len;
    endfunction

    function automatic logic [7:0] frame_lookup(input mode_e m, input logic [3:0] idx);
        logic [7:0] f;
        unique case (m)
            MODE_FLASH: f = idx[0] ? FRAME_ON : FRAME_OFF;
            MODE_CHASE: f = FRAME_LAMP0 << idx[2:0];
            MODE_ALT:   f = idx[0] ? FRAME_ALT_B : FRAME_ALT_A;
            MODE_AUTO: begin
                // AUTO = FLASH frames, then the 8 CHASE frames, then the ALT frames
                if (idx == 4'd0)
                    f = FRAME_OFF;
                else if (idx == 4'd1)
                    f = FRAME_ON;
                else if (idx <= 4'd9)
                    f = FRAME_LAMP0 << 3'(idx - 4'd2);
                else if (idx == 4'd10)
                    f = FRAME_ALT_A;
                else if (idx == 4'd11)
                    f = FRAME_ALT_B;
                else
                    f = FRAME_OFF;
            end
            default:    f = FRAME_OFF;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/light_tick.sv
// Frame prescaler: one-cycle tick after every (TICK_DIV << speed) enabled cycles.
module light_tick
    import light_pkg::*;
#(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       clear,
    input  logic [1:0] speed,
    output logic       tick
);

    localparam int unsigned CW = 11;

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_last;

    always_comb begin
        w_last = CW'((TICK_DIV << speed) - 32'd1);
        tick   = enable && !clear && (r_cnt == w_last);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= tick ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/light_ctrl.sv
// Lamp pattern sequencer: IDLE/RUN/PAUSE control over fixed frame tables.
module light_ctrl
    import light_pkg::*;
#(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       step,
    input  logic [1:0] mode,
    input  logic [1:0] speed,
    output logic [7:0] q,
    output logic       busy,
    output logic       pattern_done
);

    state_e     r_state;
    mode_e      r_mode;
    logic [1:0] r_speed;
    logic [3:0] r_idx;
    logic [7:0] r_q;
    logic       r_busy;
    logic       r_done;

    state_e     w_state_nxt;
    mode_e      w_mode_nxt;
    logic [1:0] w_speed_nxt;
    logic [3:0] w_idx_nxt;
    logic [3:0] w_last;
    logic       w_enable;
    logic       w_clear;
    logic       w_tick;
    logic       w_adv;
    logic       w_wrap;

    // Prescaler control kept apart from the FSM block so tick never feeds back into it
    assign w_enable = (r_state == ST_RUN) && !stop;
    assign w_clear  = !stop && start && ((r_state == ST_IDLE) || (r_state == ST_PAUSE));

    light_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .enable (w_enable),
        .clear  (w_clear),
        .speed  (r_speed),
        .tick   (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_speed_nxt = r_speed;
        w_idx_nxt   = r_idx;
        w_adv       = 1'b0;
        w_last      = table_len(r_mode) - 4'd1;
        unique case (r_state)
            ST_IDLE: begin
                if (start && !stop) begin
                    w_state_nxt = ST_RUN;
                    w_mode_nxt  = mode_e'(mode);
                    w_speed_nxt = speed;
                    w_idx_nxt   = '0;
                end
            end
            ST_RUN: begin
                if (stop)
                    w_state_nxt = ST_PAUSE;
                else
                    w_adv = w_tick;
            end
            ST_PAUSE: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = '0;
                end else if (start) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_adv = step;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        w_wrap = w_adv && (r_idx == w_last);
        if (w_adv)
            w_idx_nxt = w_wrap ? '0 : r_idx + 4'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode  <= MODE_FLASH;
            r_speed <= '0;
            r_idx   <= '0;
            r_q     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_mode  <= w_mode_nxt;
            r_speed <= w_speed_nxt;
            r_idx   <= w_idx_nxt;
            r_q     <= (w_state_nxt == ST_IDLE) ? FRAME_OFF : frame_lookup(w_mode_nxt, w_idx_nxt);
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_done  <= w_wrap;
        end
    end

    assign q            = r_q;
    assign busy         = r_busy;
    assign pattern_done = r_done;

endmodule
